fetch_unit: RTL and testbench

- Parametrised instruction-fetch stage for the MIPS pipeline: PC register, on-chip instruction memory with a program-load port, and IF/ID output register.
- Adds branch flush, sticky HALT detection, out-of-range PC trapping, and single-step operation via i_valid.
- Sits between the debug/loader unit, which writes the program, and the decode stage, which consumes the instruction, PC+4 and the rs/rt fields.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/instruction_memory.sv | 24 ++
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch stage: the special instruction
// encodings and the bit positions of the rs/rt fields.
package fetch_pkg;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

endpackage

// File: rtl/instruction_memory.sv
// Instruction store: one synchronous write port for the loader and one
// combinational read port for fetch. A read during a write returns the old word.
module instruction_memory #(
  parameter int NB_INSTR    = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int NB_MEM_ADDR = 8
) (
  input  logic                   i_clock,
  input  logic                   i_write_en,
  input  logic [NB_MEM_ADDR-1:0] i_write_addr,
  input  logic [NB_INSTR-1:0]    i_write_data,
  input  logic [NB_MEM_ADDR-1:0] i_read_addr,
  output logic [NB_INSTR-1:0]    o_read_data
);

  logic [NB_INSTR-1:0] mem [MEM_DEPTH];

  always_ff @(posedge i_clock) begin
    if (i_write_en) mem[i_write_addr] <= i_write_data;
  end

  assign o_read_data = mem[i_read_addr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, instruction memory and the IF/ID
// register, with branch flush, sticky halt/trap and single-step via i_valid.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int NB_PC       = 32,
  parameter int NB_INSTR    = 32,
  parameter int NB_REG_ADDR = 5,
  parameter int MEM_DEPTH   = 256,
  parameter int NB_MEM_ADDR = 8
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic                   i_stall,
  input  logic                   i_pc_src,
  input  logic [NB_PC-1:0]       i_pc_target,
  input  logic                   i_load_en,
  input  logic [NB_MEM_ADDR-1:0] i_load_addr,
  input  logic [NB_INSTR-1:0]    i_load_data,
  output logic [NB_INSTR-1:0]    o_instruction,
  output logic [NB_PC-1:0]       o_pc_4,
  output logic [NB_REG_ADDR-1:0] o_rs,
  output logic [NB_REG_ADDR-1:0] o_rt,
  output logic                   o_halt,
  output logic                   o_error,
  output logic [NB_PC-1:0]       o_pc
);

  localparam logic [NB_PC-1:0]    PC_STEP  = NB_PC'(4);
  localparam logic [NB_PC-1:0]    PC_LIMIT = NB_PC'(MEM_DEPTH * 4);
  localparam logic [NB_INSTR-1:0] NOP_W    = NB_INSTR'(NOP_INSTR);
  localparam logic [NB_INSTR-1:0] HALT_W   = NB_INSTR'(HALT_INSTR);

  logic [NB_PC-1:0]    pc;
  logic [NB_PC-1:0]    pc_plus_4;
  logic [NB_INSTR-1:0] instr_q;
  logic [NB_PC-1:0]    pc_4_q;
  logic                halt_q;
  logic                error_q;
  logic [NB_INSTR-1:0] mem_word;
  logic                adv;
  logic                pc_trap;

  instruction_memory #(
    .NB_INSTR    (NB_INSTR),
    .MEM_DEPTH   (MEM_DEPTH),
    .NB_MEM_ADDR (NB_MEM_ADDR)
  ) u_imem (
    .i_clock      (i_clock),
    .i_write_en   (i_load_en),
    .i_write_addr (i_load_addr),
    .i_write_data (i_load_data),
    .i_read_addr  (pc[NB_MEM_ADDR+1:2]),
    .o_read_data  (mem_word)
  );

  assign adv       = i_valid & ~halt_q;
  assign pc_plus_4 = pc + PC_STEP;
  // A wrapped PC+4 lands at a low address, so only the current PC needs checking.
  assign pc_trap   = (pc[1:0] != 2'b00) || (pc >= PC_LIMIT);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pc      <= '0;
      instr_q <= NOP_W;
      pc_4_q  <= '0;
      halt_q  <= 1'b0;
      error_q <= 1'b0;
    end else if (adv) begin
      if (i_pc_src) begin
        pc      <= i_pc_target;
        instr_q <= NOP_W;
        pc_4_q  <= '0;
      end else if (!i_stall) begin
        if (pc_trap) begin
          instr_q <= NOP_W;
          pc_4_q  <= '0;
          halt_q  <= 1'b1;
          error_q <= 1'b1;
        end else if (mem_word == HALT_W) begin
          // HALT travels down the pipe while the PC parks on it.
          instr_q <= mem_word;
          pc_4_q  <= pc_plus_4;
          halt_q  <= 1'b1;
        end else begin
          instr_q <= mem_word;
          pc_4_q  <= pc_plus_4;
          pc      <= pc_plus_4;
        end
      end
    end
  end

  assign o_instruction = instr_q;
  assign o_pc_4        = pc_4_q;
  assign o_rs          = instr_q[RS_MSB:RS_LSB];
  assign o_rt          = instr_q[RT_MSB:RT_LSB];
  assign o_halt        = halt_q;
  assign o_error       = error_q;
  assign o_pc          = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural model predicts the state after
// each edge and a monitor compares the DUT outputs one step later.
module tb_fetch_unit;

  logic        i_clock;
  logic        i_reset;
  logic        i_valid;
  logic        i_stall;
  logic        i_pc_src;
  logic [31:0] i_pc_target;
  logic        i_load_en;
  logic [7:0]  i_load_addr;
  logic [31:0] i_load_data;
  logic [31:0] o_instruction;
  logic [31:0] o_pc_4;
  logic [4:0]  o_rs;
  logic [4:0]  o_rt;
  logic        o_halt;
  logic        o_error;
  logic [31:0] o_pc;

  fetch_unit dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_valid       (i_valid),
    .i_stall       (i_stall),
    .i_pc_src      (i_pc_src),
    .i_pc_target   (i_pc_target),
    .i_load_en     (i_load_en),
    .i_load_addr   (i_load_addr),
    .i_load_data   (i_load_data),
    .o_instruction (o_instruction),
    .o_pc_4        (o_pc_4),
    .o_rs          (o_rs),
    .o_rt          (o_rt),
    .o_halt        (o_halt),
    .o_error       (o_error),
    .o_pc          (o_pc)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] pc;
    logic        halt;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  logic [31:0] m_mem [256];
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_halt, m_err;

  localparam logic [31:0] PROG0 = 32'h2001_0005;
  localparam logic [31:0] PROG1 = 32'h2002_0007;
  localparam logic [31:0] PROG2 = 32'h0022_1820;
  localparam logic [31:0] PROG3 = 32'hFFFF_FFFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: every edge the DUT presents a new IF/ID + PC state
  always @(posedge i_clock) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("instruction", o_instruction, e.instr);
      check("pc_4", o_pc_4, e.pc4);
      check("pc", o_pc, e.pc);
      check("halt", {31'b0, o_halt}, {31'b0, e.halt});
      check("error", {31'b0, o_error}, {31'b0, e.err});
      check("rs", {27'b0, o_rs}, {27'b0, e.instr[25:21]});
      check("rt", {27'b0, o_rt}, {27'b0, e.instr[20:16]});
    end
  end

  task automatic step(input logic rst, input logic v, input logic st, input logic ps,
                      input logic [31:0] tgt, input logic le, input logic [7:0] la,
                      input logic [31:0] ld);
    logic [31:0] w;
    exp_t e;
    @(negedge i_clock);
    i_reset = rst; i_valid = v; i_stall = st; i_pc_src = ps; i_pc_target = tgt;
    i_load_en = le; i_load_addr = la; i_load_data = ld;
    w = m_mem[m_pc[9:2]];
    if (rst) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_halt = 0; m_err = 0;
    end else if (v && !m_halt) begin
      if (ps) begin
        m_pc = tgt; m_instr = 0; m_pc4 = 0;
      end else if (!st) begin
        if ((m_pc % 4) != 0 || (m_pc / 4) >= 256) begin
          m_halt = 1; m_err = 1; m_instr = 0; m_pc4 = 0;
        end else if (w == 32'hFFFF_FFFF) begin
          m_instr = w; m_pc4 = m_pc + 4; m_halt = 1;
        end else begin
          m_instr = w; m_pc4 = m_pc + 4; m_pc = m_pc + 4;
        end
      end
    end
    if (le) m_mem[la] = ld;
    e.instr = m_instr; e.pc4 = m_pc4; e.pc = m_pc; e.halt = m_halt; e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic branch(input logic [31:0] tgt, input logic st);
    step(0, 1, st, 1, tgt, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] w;
    int wait_cycles;
    i_reset = 1; i_valid = 0; i_stall = 0; i_pc_src = 0; i_pc_target = 0;
    i_load_en = 0; i_load_addr = 0; i_load_data = 0;
    for (int a = 0; a < 256; a++) m_mem[a] = 32'h0;
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_halt = 0; m_err = 0;

    // Load the whole memory while held in reset
    for (int a = 0; a < 256; a++) begin
      case (a)
        0: w = PROG0;
        1: w = PROG1;
        2: w = PROG2;
        3: w = PROG3;
        default: begin
          w = $urandom;
          if (w == 32'hFFFF_FFFF) w = 32'hFFFF_FFFE;
        end
      endcase
      step(1, 0, 0, 0, 0, 1, 8'(a), w);
    end

    // Straight-line run into HALT, then reset while halted
    do_reset(); run(8);
    do_reset(); run(2);

    // Stall after the first fetch
    do_reset(); run(1);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    run(3);

    // Branch at PC=4, plain and with a simultaneous stall
    do_reset(); run(1); branch(32'h8, 0); run(2);
    do_reset(); run(1); branch(32'h8, 1); run(2);

    // Out-of-range and misaligned targets trap
    do_reset(); branch(32'd1024, 0); run(2);
    do_reset(); branch(32'h6, 0); run(2);
    // Branch ignored once halted
    branch(32'h0, 0);

    // Single-step: one pulse every five cycles
    do_reset();
    for (int p = 0; p < 5; p++) begin
      step(0, 1, 0, 0, 0, 0, 0, 0);
      for (int q = 0; q < 4; q++) step(0, 0, 0, 0, 0, 0, 0, 0);
    end

    // Overwrite word 2 in the same cycle it is fetched, then see the new word
    do_reset(); run(2);
    step(0, 1, 0, 0, 0, 1, 8'd2, 32'h0043_2025);
    do_reset(); run(4);
    step(0, 0, 0, 0, 0, 1, 8'd2, PROG2);
    do_reset(); run(5);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic rst, v, st, ps, le;
      logic [31:0] tgt, ld;
      rst = ($urandom_range(0, 99) < 3);
      v   = ($urandom_range(0, 99) < 75);
      st  = ($urandom_range(0, 99) < 20);
      ps  = ($urandom_range(0, 99) < 10);
      case ($urandom_range(0, 9))
        0:       tgt = $urandom;
        1:       tgt = {22'b0, $urandom_range(0, 255), 2'b00} + 32'($urandom_range(1, 3));
        2:       tgt = 32'd1020 + 32'(4 * $urandom_range(0, 2));
        default: tgt = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      endcase
      le = ($urandom_range(0, 99) < 15);
      ld = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
      step(rst, v, st, ps, tgt, le, 8'($urandom_range(0, 255)), ld);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge i_clock);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
